// File: rtl/traceback_stream.sv
// Smith-Waterman traceback: walks the direction matrix from the max-score cell and
// streams framed symbol pairs. Optional TRACEBACK_STATS_EN adds match/mismatch/gap counters.
module traceback_stream #(
  parameter int SEQ_LEN  = 32,
  parameter int LETTER_W = 2,
  parameter int PKT_W    = 8,
  parameter int RD_LAT   = 1,
  parameter int COORD_W  = $clog2(SEQ_LEN + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [COORD_W-1:0]           i_max_row,
  input  logic [COORD_W-1:0]           i_max_col,
  input  logic [SEQ_LEN*LETTER_W-1:0]  i_query_seq,
  input  logic [SEQ_LEN*LETTER_W-1:0]  i_database_seq,
  output logic                         o_rd_en,
  output logic [COORD_W-1:0]           o_rd_row,
  output logic [COORD_W-1:0]           o_rd_col,
  input  logic [PKT_W-1:0]             i_rd_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [LETTER_W:0]            o_q_sym,
  output logic [LETTER_W:0]            o_d_sym,
  output logic                         o_busy,
  output logic                         o_done,
`ifdef TRACEBACK_STATS_EN
  output logic [COORD_W:0]             o_match_cnt,
  output logic [COORD_W:0]             o_mismatch_cnt,
  output logic [COORD_W:0]             o_gap_cnt,
`endif
  output logic [COORD_W:0]             o_aln_len
);

  localparam int SYM_W = LETTER_W + 1;
  localparam logic [SYM_W-1:0]   MARK     = {1'b1, {LETTER_W{1'b0}}};
  localparam logic [SYM_W-1:0]   GAP      = {SYM_W{1'b1}};
  localparam logic [1:0]         DIR_LEFT = 2'b01;
  localparam logic [1:0]         DIR_TOP  = 2'b10;
  localparam logic [2:0]         LAT      = 3'(RD_LAT);
  localparam logic [COORD_W-1:0] ZERO_C   = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE_C    = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W:0]   ONE_L    = {{COORD_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_SMARK, S_FETCH, S_WAIT, S_EMIT, S_EMARK} state_t;

  // Coordinate pos selects letter pos-1; pos 0 has no letter.
  function automatic logic [LETTER_W-1:0] letter_at(
    input logic [SEQ_LEN*LETTER_W-1:0] seq,
    input logic [COORD_W-1:0]          pos
  );
    logic [LETTER_W-1:0] res;
    res = {LETTER_W{1'b0}};
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (pos == COORD_W'(i + 1)) res = seq[i*LETTER_W +: LETTER_W];
    end
    return res;
  endfunction

  state_t               r_state;
  logic [COORD_W-1:0]   r_row;
  logic [COORD_W-1:0]   r_col;
  logic [2:0]           r_lat_cnt;
  logic [1:0]           r_dir;

  logic [1:0]           w_dir;
  logic                 w_stop;
  logic [SYM_W-1:0]     w_q_pair;
  logic [SYM_W-1:0]     w_d_pair;
  logic [COORD_W-1:0]   w_next_row;
  logic [COORD_W-1:0]   w_next_col;
  logic                 w_next_edge;

  assign w_dir  = i_rd_data[1:0];
  assign w_stop = i_rd_data[PKT_W-1];

  // Symbol pair for the packet arriving from matrix memory.
  always_comb begin
    w_q_pair = {1'b0, letter_at(i_query_seq, r_col)};
    w_d_pair = {1'b0, letter_at(i_database_seq, r_row)};
    case (w_dir)
      DIR_LEFT: w_d_pair = GAP;
      DIR_TOP:  w_q_pair = GAP;
      default:  w_q_pair = {1'b0, letter_at(i_query_seq, r_col)};
    endcase
  end

  // Next cell after the registered direction; saturates at zero.
  always_comb begin
    w_next_row = r_row;
    w_next_col = r_col;
    case (r_dir)
      DIR_LEFT: w_next_col = (r_col != ZERO_C) ? r_col - ONE_C : ZERO_C;
      DIR_TOP:  w_next_row = (r_row != ZERO_C) ? r_row - ONE_C : ZERO_C;
      default: begin
        w_next_row = (r_row != ZERO_C) ? r_row - ONE_C : ZERO_C;
        w_next_col = (r_col != ZERO_C) ? r_col - ONE_C : ZERO_C;
      end
    endcase
    if (w_next_row == ZERO_C || w_next_col == ZERO_C) w_next_edge = 1'b1;
    else                                              w_next_edge = 1'b0;
  end

  // Traceback FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_row          <= ZERO_C;
      r_col          <= ZERO_C;
      r_lat_cnt      <= 3'd0;
      r_dir          <= 2'b00;
      o_rd_en        <= 1'b0;
      o_rd_row       <= ZERO_C;
      o_rd_col       <= ZERO_C;
      o_out_valid    <= 1'b0;
      o_q_sym        <= MARK;
      o_d_sym        <= MARK;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_aln_len      <= {(COORD_W+1){1'b0}};
`ifdef TRACEBACK_STATS_EN
      o_match_cnt    <= {(COORD_W+1){1'b0}};
      o_mismatch_cnt <= {(COORD_W+1){1'b0}};
      o_gap_cnt      <= {(COORD_W+1){1'b0}};
`endif
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_row       <= i_max_row;
            r_col       <= i_max_col;
            o_aln_len   <= {(COORD_W+1){1'b0}};
`ifdef TRACEBACK_STATS_EN
            o_match_cnt    <= {(COORD_W+1){1'b0}};
            o_mismatch_cnt <= {(COORD_W+1){1'b0}};
            o_gap_cnt      <= {(COORD_W+1){1'b0}};
`endif
            o_busy      <= 1'b1;
            o_out_valid <= 1'b1;
            o_q_sym     <= MARK;
            o_d_sym     <= MARK;
            r_state     <= S_SMARK;
          end
        end
        S_SMARK: begin
          if (i_out_ready) begin
            if (r_row == ZERO_C || r_col == ZERO_C) begin
              r_state <= S_EMARK;
            end else begin
              o_out_valid <= 1'b0;
              o_rd_en     <= 1'b1;
              o_rd_row    <= r_row;
              o_rd_col    <= r_col;
              r_state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          o_rd_en   <= 1'b0;
          r_lat_cnt <= 3'd1;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat_cnt == LAT) begin
            r_dir       <= w_dir;
            o_out_valid <= 1'b1;
            if (w_stop) begin
              o_q_sym <= MARK;
              o_d_sym <= MARK;
              r_state <= S_EMARK;
            end else begin
              o_q_sym <= w_q_pair;
              o_d_sym <= w_d_pair;
              r_state <= S_EMIT;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        S_EMIT: begin
          if (i_out_ready) begin
            o_aln_len <= o_aln_len + ONE_L;
            r_row     <= w_next_row;
            r_col     <= w_next_col;
`ifdef TRACEBACK_STATS_EN
            if (r_dir == DIR_LEFT || r_dir == DIR_TOP) o_gap_cnt      <= o_gap_cnt + ONE_L;
            else if (o_q_sym == o_d_sym)               o_match_cnt    <= o_match_cnt + ONE_L;
            else                                       o_mismatch_cnt <= o_mismatch_cnt + ONE_L;
`endif
            if (w_next_edge) begin
              o_q_sym <= MARK;
              o_d_sym <= MARK;
              r_state <= S_EMARK;
            end else begin
              o_out_valid <= 1'b0;
              o_rd_en     <= 1'b1;
              o_rd_row    <= w_next_row;
              o_rd_col    <= w_next_col;
              r_state     <= S_FETCH;
            end
          end
        end
        S_EMARK: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          o_rd_en     <= 1'b0;
          o_out_valid <= 1'b0;
          o_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/traceback_stream.md
# traceback_stream

Parametrised traceback engine for the Smith-Waterman datapath. Starting from the max-score cell reported by matrix calculation, it walks the stored direction matrix back to a zero-score cell or to row/column 0. Each step it issues a read to matrix memory and tolerates a configurable read latency. It streams aligned symbol pairs to the output buffer over a valid/ready handshake with full backpressure, framed by start and end markers.

## Interface
Parameters:
- SEQ_LEN, 32: letters per sequence; the matrix spans rows/cols 0..SEQ_LEN.
- LETTER_W, 2: bits per letter.
- PKT_W, 8: matrix memory word width. Bits [1:0] are the direction; bit PKT_W-1 is the stop flag (cell score 0).
- RD_LAT, 1: matrix memory read latency in cycles, legal range 1..4.
- COORD_W, $clog2(SEQ_LEN+1): row/column coordinate width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a traceback; honoured only in IDLE.
- max_row  in  COORD_W  start row, sampled on start.
- max_col  in  COORD_W  start column, sampled on start.
- query_seq  in  SEQ_LEN*LETTER_W  query letters; column c selects letter c-1.
- database_seq  in  SEQ_LEN*LETTER_W  database letters; row r selects letter r-1.
- rd_en  out  1  matrix memory read strobe.
- rd_row  out  COORD_W  read row address.
- rd_col  out  COORD_W  read column address.
- rd_data  in  PKT_W  packet, valid exactly RD_LAT cycles after rd_en.
- out_valid  out  1  output pair valid.
- out_ready  in  1  consumer accepts the pair.
- q_sym  out  LETTER_W+1  query symbol.
- d_sym  out  LETTER_W+1  database symbol.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the END marker is accepted.
- aln_len  out  COORD_W+1  number of letter/gap pairs emitted in the current or last run.

## Operation
- Symbol encoding:
  - Letter: {1'b0, letter}.
  - GAP: all ones.
  - MARK (start/end): {1'b1, zeros}.
- Direction encoding: 2'b01 LEFT, 2'b10 TOP, 2'b00 and 2'b11 DIAG.
- Per-step output and coordinate update for cell (r,c):
  - DIAG: q=letter(c), d=letter(r); r--, c--.
  - LEFT: q=letter(c), d=GAP; c--.
  - TOP: q=GAP, d=letter(r); r--.
- FSM states: IDLE, SMARK, FETCH, WAIT, EMIT, EMARK.
  - IDLE --start--> SMARK. Latches max_row/max_col and clears aln_len.
  - SMARK presents MARK/MARK. On accept: if r==0 or c==0, go to EMARK; otherwise go to FETCH.
  - FETCH asserts rd_en with rd_row=r, rd_col=c for exactly one cycle, then goes to WAIT.
  - WAIT counts RD_LAT cycles, registers rd_data, then goes to EMIT. If the stop flag is set, it goes to EMARK instead and emits no pair.
  - EMIT presents the pair. On accept: aln_len++ and coordinates update; if the new r==0 or c==0, go to EMARK, otherwise go to FETCH.
  - EMARK presents MARK/MARK. On accept: pulse done and go to IDLE.
- Coordinates never decrement below 0; the zero check precedes every fetch.
- While out_valid is high and out_ready is low, q_sym, d_sym and out_valid are held stable.
- start outside IDLE is ignored.
- rst at any time returns the block to IDLE, abandoning any traceback in progress.

## Timing
- Reset values:
  - rd_en, out_valid, busy, done: 0.
  - rd_row, rd_col, aln_len: 0.
  - q_sym, d_sym: MARK.
- busy rises the cycle after start.
- SMARK out_valid is asserted in the cycle after start.
- Step latency with out_ready held high: 1 (FETCH) + RD_LAT (WAIT) + 1 (EMIT) = RD_LAT+2 cycles per pair.
- done rises the cycle after the EMARK handshake; busy falls in that same cycle.
- A new start is accepted the cycle after done.
- At most one read is outstanding; rd_en is never asserted in WAIT or EMIT.

## Configuration
- TRACEBACK_STATS_EN defined:
  - Adds outputs match_cnt, mismatch_cnt and gap_cnt, each COORD_W+1 bits.
  - The counters clear on start and update on each accepted EMIT.
  - A DIAG step counts as a match when the two letters are equal, otherwise as a mismatch.
  - A LEFT or TOP step counts as a gap.
- TRACEBACK_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Pure diagonal: SEQ_LEN=4, start (3,3), all packets DIAG, out_ready=1 -> MARK, three letter pairs, then MARK. aln_len=3. done pulses 1 cycle after the END handshake. Reads issued at (3,3), (2,2), (1,1).
- Mixed path: start (4,4), packets LEFT, TOP, DIAG, then stop at (2,2) -> pairs (q,GAP), (GAP,d), (q,d), then MARK. aln_len=3. With stats enabled: gap_cnt=2, match or mismatch total=1.
- Boundary: start (0,5) -> MARK, MARK, done; no rd_en is issued.
- Backpressure: out_ready held low for 5 cycles during an EMIT -> q_sym and d_sym remain stable, and no rd_en is issued until the pair is accepted.
- RD_LAT=3: rd_data delivered exactly 3 cycles after rd_en is captured correctly, giving 5 cycles per step.
- Reset mid-walk: rst asserted in WAIT -> IDLE next cycle. All outputs return to their reset values, and a following start runs normally.
